// File: rtl/instr_fetch_cache_if.sv
// Memory-bus bundle between the instruction cache (master) and the bus (slave).
interface instr_fetch_cache_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              we;
  logic              start;
  logic [DATA_W-1:0] q;
  logic              done;

  modport master (output addr, data, we, start, input q, done);
  modport slave  (input addr, data, we, start, output q, done);
endinterface

// File: rtl/instr_fetch_cache.sv
// instr_fetch_cache: direct-mapped, one-word-per-line instruction cache between
// the fetch stage and the memory bus. Hits return in the same cycle; misses run
// one bus read, fill the line and forward the word on the bus_done cycle.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module instr_fetch_cache #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [DATA_W-1:0] q,
  input  logic              clear,
  input  logic              hold,
  input  logic              invalidate,
  instr_fetch_cache_if.master bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses
`endif
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [DEPTH-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] fill_addr;
  logic              kill;
  logic              hold_hit;
  logic [DATA_W-1:0] hold_q;

  logic [IDX_W-1:0]  idx, fill_idx;
  logic [TAG_W-1:0]  tag, fill_tag;
  logic              lookup_hit;
  logic              fill_start;
  logic              line_we;
  logic              hit_c;
  logic [DATA_W-1:0] q_c;

  assign idx      = addr[IDX_W-1:0];
  assign tag      = addr[ADDR_W-1:IDX_W];
  assign fill_idx = fill_addr[IDX_W-1:0];
  assign fill_tag = fill_addr[ADDR_W-1:IDX_W];

  assign lookup_hit = valid[idx] && (tag_mem[idx] == tag) && !clear && (state == S_IDLE);

  assign bus.addr  = fill_addr;
  assign bus.data  = '0;
  assign bus.we    = 1'b0;
  assign bus.start = (state == S_FILL);

  assign hit = hit_c;
  assign q   = q_c;

  // Next-state, fetch response and fill/write strobes.
  always_comb begin
    state_n    = state;
    hit_c      = 1'b0;
    q_c        = '0;
    fill_start = 1'b0;
    line_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (hold && !clear) begin
          hit_c = hold_hit;
          q_c   = hold_q;
        end else if (lookup_hit) begin
          hit_c = 1'b1;
          q_c   = data_mem[idx];
        end else if (!clear) begin
          fill_start = 1'b1;
          state_n    = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.done) begin
          state_n = S_IDLE;
          line_we = !kill && !invalidate;
          if ((addr == fill_addr) && !clear && !hold && !kill && !invalidate) begin
            hit_c = 1'b1;
            q_c   = bus.q;
          end
        end else if (clear) begin
          state_n = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (bus.done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, valid bits, fill address and kill flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      valid     <= '0;
      fill_addr <= '0;
      kill      <= 1'b0;
    end else begin
      state <= state_n;
      if (invalidate) valid <= '0;
      else if (line_we) valid[fill_idx] <= 1'b1;
      if (fill_start) fill_addr <= addr;
      if (state_n == S_IDLE) kill <= 1'b0;
      else if ((state == S_FILL) && invalidate) kill <= 1'b1;
    end
  end

  // Last presented response, replayed while the pipeline is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_hit <= 1'b0;
      hold_q   <= '0;
    end else if (clear) begin
      hold_hit <= 1'b0;
      hold_q   <= '0;
    end else if (!hold) begin
      hold_hit <= hit_c;
      hold_q   <= q_c;
    end
  end

  // Tag/data arrays; contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.q;
    end
  end

`ifdef ICACHE_PERF_EN
  // Saturating hit/miss counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (lookup_hit && !hold && (perf_hits != 32'hFFFF_FFFF))
        perf_hits <= perf_hits + 32'd1;
      if (fill_start && (perf_misses != 32'hFFFF_FFFF))
        perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule
